nfca_rx_tobits: RTL and testbench

NFCA_RX_TOBITS -- requirements
Module: nfca_rx_tobits

---
 rtl/nfca_rx_tobits.sv | 135 +++++++++++++
 tb/tb_nfca_rx_tobits.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfca_rx_tobits.sv
// NFC-A (106 kbps, Manchester/ASK) receive bit decoder: turns ASK samples into data bits,
// a collision flag and an end-of-frame strobe. Define NFCA_RX_COLLISION_EN to report collisions on rx_col.
module nfca_rx_tobits (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_on,
    input  logic        rx_ask_en,
    input  logic        rx_ask,
    output logic        rx_bit_en,
    output logic        rx_bit,
    output logic        rx_col,
    output logic        rx_end,
    output logic [11:0] rx_bitcnt
);

    typedef enum logic [2:0] {IDLE, SOF1, SOF2, BIT, END} state_t;

    state_t      state;
    logic [4:0]  scnt;
    logic [3:0]  ones;
    logic        h1;
    logic [11:0] bitcnt;
    logic [3:0]  ones_n;
    logic        half_mod;
`ifdef NFCA_RX_COLLISION_EN
    logic        col_q;
`endif

    // The ones count includes the current sample, so the half decision is ready on its 12th sample.
    assign ones_n   = ones + {3'd0, rx_ask};
    assign half_mod = (ones_n >= 4'd4);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            scnt      <= 5'd0;
            ones      <= 4'd0;
            h1        <= 1'b0;
            bitcnt    <= 12'd0;
            rx_bit_en <= 1'b0;
            rx_bit    <= 1'b0;
            rx_end    <= 1'b0;
            rx_bitcnt <= 12'd0;
`ifdef NFCA_RX_COLLISION_EN
            col_q     <= 1'b0;
`endif
        end else begin
            rx_bit_en <= 1'b0;
            rx_end    <= 1'b0;
            if (!rx_on) begin
                state  <= IDLE;
                scnt   <= 5'd0;
                ones   <= 4'd0;
                h1     <= 1'b0;
                bitcnt <= 12'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_ask_en && rx_ask) begin
                            state  <= SOF1;
                            scnt   <= 5'd1;
                            ones   <= 4'd1;
                            bitcnt <= 12'd0;
                        end
                    end
                    SOF1: begin
                        if (rx_ask_en) begin
                            if (scnt == 5'd11) begin
                                scnt  <= 5'd0;
                                ones  <= 4'd0;
                                state <= half_mod ? SOF2 : IDLE;
                            end else begin
                                scnt <= scnt + 5'd1;
                                ones <= ones_n;
                            end
                        end
                    end
                    SOF2: begin
                        if (rx_ask_en) begin
                            if (scnt == 5'd11) begin
                                scnt  <= 5'd0;
                                ones  <= 4'd0;
                                state <= half_mod ? IDLE : BIT;
                            end else begin
                                scnt <= scnt + 5'd1;
                                ones <= ones_n;
                            end
                        end
                    end
                    BIT: begin
                        if (rx_ask_en) begin
                            if (scnt == 5'd11) begin
                                h1   <= half_mod;
                                ones <= 4'd0;
                                scnt <= 5'd12;
                            end else if (scnt == 5'd23) begin
                                scnt <= 5'd0;
                                ones <= 4'd0;
                                // Bit value follows the first half; both halves modulated is a collision.
                                if (h1 || half_mod) begin
                                    rx_bit_en <= 1'b1;
                                    rx_bit    <= h1;
`ifdef NFCA_RX_COLLISION_EN
                                    col_q     <= h1 && half_mod;
`endif
                                    if (bitcnt != 12'hFFF)
                                        bitcnt <= bitcnt + 12'd1;
                                end else begin
                                    state <= END;
                                end
                            end else begin
                                scnt <= scnt + 5'd1;
                                ones <= ones_n;
                            end
                        end
                    end
                    END: begin
                        rx_end    <= 1'b1;
                        rx_bitcnt <= bitcnt;
                        bitcnt    <= 12'd0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef NFCA_RX_COLLISION_EN
    assign rx_col = col_q;
`else
    assign rx_col = 1'b0;
`endif

endmodule

// File: tb/tb_nfca_rx_tobits.sv
// Bench for nfca_rx_tobits: a window-sum reference model over the buffered sample stream,
// checked every cycle, plus literal expectations for directed frames.
module tb_nfca_rx_tobits;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_on = 1'b1;
    logic        rx_ask_en = 1'b0;
    logic        rx_ask = 1'b0;
    logic        rx_bit_en, rx_bit, rx_col, rx_end;
    logic [11:0] rx_bitcnt;

    nfca_rx_tobits dut (
        .clk(clk), .rstn(rstn), .rx_on(rx_on), .rx_ask_en(rx_ask_en), .rx_ask(rx_ask),
        .rx_bit_en(rx_bit_en), .rx_bit(rx_bit), .rx_col(rx_col), .rx_end(rx_end),
        .rx_bitcnt(rx_bitcnt)
    );

    always #5 clk = ~clk;

`ifdef NFCA_RX_COLLISION_EN
    localparam bit COL_EN = 1'b1;
`else
    localparam bit COL_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: frame = buffered samples from the first '1'; decisions are
    // ones-sums over fixed 12-sample windows of that buffer.
    int   smp[$];
    bit   m_act = 0, m_endp = 0;
    int   m_nb = 0;
    bit   m_bit_en = 0, m_bit = 0, m_col = 0, m_end = 0;
    int   m_cnt = 0;

    function automatic int ssum(input int a, input int b);
        int s = 0;
        for (int i = a; i <= b; i++) s += smp[i];
        return s;
    endfunction

    always @(posedge clk) begin
        int  n;
        bit  h1, h2;
        m_bit_en = 0;
        m_end    = 0;
        if (!rstn) begin
            m_act = 0; m_endp = 0; m_nb = 0; smp.delete();
            m_bit = 0; m_col = 0; m_cnt = 0;
        end else if (!rx_on) begin
            m_act = 0; m_endp = 0; m_nb = 0; smp.delete();
        end else if (m_endp) begin
            m_end = 1; m_cnt = m_nb; m_endp = 0; m_act = 0; m_nb = 0;
        end else if (rx_ask_en) begin
            if (!m_act) begin
                if (rx_ask) begin
                    m_act = 1; m_nb = 0; smp.delete(); smp.push_back(1);
                end
            end else begin
                smp.push_back(int'(rx_ask));
                n = smp.size();
                if (n == 12 && ssum(0, 11) < 4) m_act = 0;
                else if (n == 24 && ssum(12, 23) >= 4) m_act = 0;
                else if (n >= 48 && n % 24 == 0) begin
                    h1 = ssum(n - 24, n - 13) >= 4;
                    h2 = ssum(n - 12, n - 1) >= 4;
                    if (h1 || h2) begin
                        m_bit_en = 1;
                        m_bit    = h1;
                        m_col    = COL_EN && h1 && h2;
                        if (m_nb < 4095) m_nb++;
                    end else begin
                        m_endp = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("rx_bit_en", int'(rx_bit_en), int'(m_bit_en));
        chk("rx_bit",    int'(rx_bit),    int'(m_bit));
        chk("rx_col",    int'(rx_col),    int'(m_col));
        chk("rx_end",    int'(rx_end),    int'(m_end));
        chk("rx_bitcnt", int'(rx_bitcnt), m_cnt);
    end

    // Event log for the directed literal checks.
    int          mon_nbit = 0, mon_nend = 0, mon_cnt = 0;
    logic [15:0] mon_bits = '0, mon_cols = '0;
    always @(negedge clk) begin
        if (rx_bit_en) begin
            mon_nbit++;
            mon_bits = {mon_bits[14:0], rx_bit};
            mon_cols = {mon_cols[14:0], rx_col};
        end
        if (rx_end) begin
            mon_nend++;
            mon_cnt = int'(rx_bitcnt);
        end
    end

    localparam logic [11:0] HM  = 12'b011011011011;
    localparam logic [11:0] HZ  = 12'b000000000000;
    localparam logic [11:0] H3  = 12'b000000000111;
    localparam logic [11:0] H4  = 12'b000000001111;

    bit rand_on = 0;

    task automatic cyc();
        @(negedge clk); #1;
    endtask

    task automatic put_sample(input bit a);
        rx_ask_en = 1'b1; rx_ask = a;
        if (rand_on && $urandom_range(0, 299) == 0) rx_on = 1'b0;
        cyc();
        rx_on = 1'b1; rx_ask_en = 1'b0; rx_ask = 1'($urandom);
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    task automatic half(input logic [11:0] p);
        logic [11:0] q;
        q = p;
        for (int i = 11; i >= 0; i--) put_sample(q[i]);
    endtask

    task automatic sof();
        half(HM); half(HZ);
    endtask

    // v: 0 / 1 data bit, 2 collision
    task automatic dbit(input int v);
        case (v)
            0:       begin half(HZ); half(HM); end
            1:       begin half(HM); half(HZ); end
            default: begin half(HM); half(HM); end
        endcase
    endtask

    task automatic term();
        half(HZ); half(HZ);
        repeat (4) put_sample(1'b0);
        repeat (4) cyc();
    endtask

    function automatic logic [11:0] rhalf(input bit modulated);
        logic [11:0] p;
        int k;
        p = '0;
        k = modulated ? $urandom_range(4, 12) : $urandom_range(0, 3);
        while ($countones(p) < k) p[$urandom_range(0, 11)] = 1'b1;
        return p;
    endfunction

    int b0, e0;

    initial begin
        repeat (3) cyc();
        chk("reset_bit_en", int'(rx_bit_en), 0);
        chk("reset_end",    int'(rx_end),    0);
        chk("reset_bitcnt", int'(rx_bitcnt), 0);
        rstn = 1'b1;
        repeat (2) cyc();

        // Valid 8-bit frame
        b0 = mon_nbit; e0 = mon_nend;
        sof();
        dbit(1); dbit(0); dbit(1); dbit(1); dbit(0); dbit(0); dbit(1); dbit(0);
        term();
        chk("valid_nbits",  mon_nbit - b0, 8);
        chk("valid_bits",   int'(mon_bits[7:0]), 8'b10110010);
        chk("valid_nend",   mon_nend - e0, 1);
        chk("valid_bitcnt", mon_cnt, 8);

        // Threshold: 3 ones unmodulated, 4 ones modulated
        b0 = mon_nbit; e0 = mon_nend;
        sof();
        half(H3); half(H4);
        half(H4); half(H3);
        term();
        chk("thr_nbits",  mon_nbit - b0, 2);
        chk("thr_bits",   int'(mon_bits[1:0]), 2'b01);
        chk("thr_bitcnt", mon_cnt, 2);

        // Bad SOF: both halves modulated
        b0 = mon_nbit; e0 = mon_nend;
        half(HM); half(HM);
        repeat (60) put_sample(1'b0);
        chk("badsof_nbits", mon_nbit - b0, 0);
        chk("badsof_nend",  mon_nend - e0, 0);

        // Zero-bit frame
        e0 = mon_nend;
        sof(); term();
        chk("empty_nend",   mon_nend - e0, 1);
        chk("empty_bitcnt", mon_cnt, 0);

        // Collision
        b0 = mon_nbit; e0 = mon_nend;
        sof(); dbit(1); dbit(2); term();
        chk("col_nbits",  mon_nbit - b0, 2);
        chk("col_bits",   int'(mon_bits[1:0]), 2'b11);
        chk("col_flags",  int'(mon_cols[1:0]), COL_EN ? 1 : 0);
        chk("col_bitcnt", mon_cnt, 2);

        // Abort after 3 bits, then a 2-bit frame
        b0 = mon_nbit; e0 = mon_nend;
        sof(); dbit(1); dbit(1); dbit(0); half(HM);
        rx_on = 1'b0; repeat (2) cyc(); rx_on = 1'b1;
        repeat (30) put_sample(1'b0);
        chk("abort_nbits", mon_nbit - b0, 3);
        chk("abort_nend",  mon_nend - e0, 0);
        sof(); dbit(1); dbit(0); term();
        chk("abort_next_nend",   mon_nend - e0, 1);
        chk("abort_next_bitcnt", mon_cnt, 2);

        // Reset during bit 5
        sof(); dbit(0); dbit(1); dbit(1); dbit(0); half(HM);
        rstn = 1'b0; repeat (2) cyc();
        chk("rst_bit_en", int'(rx_bit_en), 0);
        chk("rst_bit",    int'(rx_bit),    0);
        chk("rst_col",    int'(rx_col),    0);
        chk("rst_end",    int'(rx_end),    0);
        chk("rst_bitcnt", int'(rx_bitcnt), 0);
        rstn = 1'b1;
        b0 = mon_nbit; e0 = mon_nend;
        half(HZ); repeat (60) put_sample(1'b0);
        chk("rst_nbits", mon_nbit - b0, 0);
        chk("rst_nend",  mon_nend - e0, 0);
        sof(); dbit(1); term();
        chk("rst_next_bitcnt", mon_cnt, 1);

        // Randomized frames with occasional rx_on drops and bad SOFs
        rand_on = 1;
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(0, 5)) put_sample(1'($urandom_range(0, 7) == 0));
            half(rhalf($urandom_range(0, 7) != 0));
            half(rhalf($urandom_range(0, 7) == 0));
            for (int b = 0; b < int'($urandom_range(0, 6)); b++) begin
                int v;
                v = $urandom_range(0, 2);
                half(rhalf(v != 0));
                half(rhalf(v != 1));
            end
            half(rhalf(0)); half(rhalf(0));
            repeat (4) put_sample(1'b0);
            repeat (3) cyc();
        end
        rand_on = 0;
        repeat (4) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
